fighter_fsm: RTL and testbench

- Parametrised per-player fighter controller: one instance per player, P1 facing right and P2 facing left, each driven by its own button source (pads or the LFSR bot).
- Adds movement, two attack strengths, damage/hitstun, back-blocking with blockstun, health and KO.
- Advances only on frame_tick. Hit detection between players is computed outside the block and arrives on hit_in.

---
 rtl/fighter_pkg.sv | 26 ++
 rtl/fighter_phase_timer.sv | 25 ++
 rtl/fighter_fsm.sv | 163 ++++++++++++++++
 tb/tb_fighter_fsm.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fighter_pkg.sv
// rtl/fighter_pkg.sv - fighter state encoding and shared helpers
package fighter_pkg;

  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_LEFT        = 4'd1;
  localparam logic [3:0] ST_RIGHT       = 4'd2;
  localparam logic [3:0] ST_A1_STARTUP  = 4'd3;
  localparam logic [3:0] ST_A1_ACTIVE   = 4'd4;
  localparam logic [3:0] ST_A1_RECOVERY = 4'd5;
  localparam logic [3:0] ST_A2_STARTUP  = 4'd6;
  localparam logic [3:0] ST_A2_ACTIVE   = 4'd7;
  localparam logic [3:0] ST_A2_RECOVERY = 4'd8;
  localparam logic [3:0] ST_DAMAGE      = 4'd9;
  localparam logic [3:0] ST_BLOCK       = 4'd10;
  localparam logic [3:0] ST_KO          = 4'd11;

  // States IDLE..A2_RECOVERY are the ones where an incoming hit lands
  function automatic logic is_hittable(input logic [3:0] s);
    return s <= ST_A2_RECOVERY;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fighter_phase_timer.sv
// rtl/fighter_phase_timer.sv - shared tick counter for timed fighter phases
module fighter_phase_timer #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          clear,
  input  logic [CW-1:0] last,
  output logic          expire
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= clear ? '0 : count + CW'(1);
    end
  end

  assign expire = (count == last);

endmodule

// File: rtl/fighter_fsm.sv
// rtl/fighter_fsm.sv - per-player fighter controller: movement, attacks, stun, health, KO
module fighter_fsm
  import fighter_pkg::*;
#(
  parameter int FACING_RIGHT = 1,
  parameter int XW           = 10,
  parameter int START_X      = 300,
  parameter int CHAR_WIDTH   = 128,
  parameter int SCREEN_WIDTH = 640,
  parameter int SPEED_FWD    = 3,
  parameter int SPEED_BACK   = 2,
  parameter int GAP          = 4,
  parameter int A1_STARTUP   = 5,
  parameter int A1_ACTIVE    = 2,
  parameter int A1_RECOVERY  = 16,
  parameter int A2_STARTUP   = 4,
  parameter int A2_ACTIVE    = 3,
  parameter int A2_RECOVERY  = 15,
  parameter int HITSTUN      = 15,
  parameter int BLOCKSTUN    = 10,
  parameter int HEALTH_MAX   = 3
) (
  input  logic                                  clk_game,
  input  logic                                  reset,
  input  logic                                  frame_tick,
  input  logic                                  btn_left,
  input  logic                                  btn_right,
  input  logic                                  btn_attack,
  input  logic [XW-1:0]                         opp_x,
  input  logic                                  hit_in,
  output logic [3:0]                            state,
  output logic [XW-1:0]                         pos_x,
  output logic                                  attack_active,
  output logic                                  attack_heavy,
  output logic [$clog2(HEALTH_MAX+1)-1:0]       health,
  output logic                                  ko
);

  localparam int HW     = $clog2(HEALTH_MAX + 1);
  localparam int MAXLEN = max_int(max_int(max_int(A1_STARTUP, A1_ACTIVE), max_int(A1_RECOVERY, A2_STARTUP)),
                                  max_int(max_int(A2_ACTIVE, A2_RECOVERY), max_int(HITSTUN, BLOCKSTUN)));
  localparam int CW     = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
  localparam int PW     = XW + 2;

  localparam logic [PW-1:0] K_CHW  = PW'(CHAR_WIDTH);
  localparam logic [PW-1:0] K_SF   = PW'(SPEED_FWD);
  localparam logic [PW-1:0] K_SB   = PW'(SPEED_BACK);
  localparam logic [PW-1:0] K_GAP  = PW'(GAP);
  localparam logic [PW-1:0] K_XMAX = PW'(SCREEN_WIDTH - CHAR_WIDTH);

  logic [3:0]    next_state;
  logic [XW-1:0] next_pos;
  logic [HW-1:0] next_health;
  logic [PW-1:0] px, ox, step_l, step_r;
  logic [CW-1:0] phase_last;
  logic          phase_expire;
  logic          moving_back;

  assign px = PW'(pos_x);
  assign ox = PW'(opp_x);
  assign moving_back = (FACING_RIGHT != 0) ? (state == ST_LEFT) : (state == ST_RIGHT);

  // Widened arithmetic so the gap and clamp tests can never wrap
  always_comb begin
    step_l = px;
    step_r = px;
    if (FACING_RIGHT != 0) begin
      step_l = (px >= K_SB) ? px - K_SB : '0;
      if (px + K_CHW + K_SF + K_GAP <= ox) step_r = px + K_SF;
    end else begin
      if (ox + K_CHW + K_GAP + K_SF <= px) step_l = px - K_SF;
      step_r = (px + K_SB >= K_XMAX) ? K_XMAX : px + K_SB;
    end
  end

  always_comb begin
    phase_last = '0;
    case (state)
      ST_A1_STARTUP:  phase_last = CW'(A1_STARTUP - 1);
      ST_A1_ACTIVE:   phase_last = CW'(A1_ACTIVE - 1);
      ST_A1_RECOVERY: phase_last = CW'(A1_RECOVERY - 1);
      ST_A2_STARTUP:  phase_last = CW'(A2_STARTUP - 1);
      ST_A2_ACTIVE:   phase_last = CW'(A2_ACTIVE - 1);
      ST_A2_RECOVERY: phase_last = CW'(A2_RECOVERY - 1);
      ST_DAMAGE:      phase_last = CW'(HITSTUN - 1);
      ST_BLOCK:       phase_last = CW'(BLOCKSTUN - 1);
      default:        phase_last = '0;
    endcase
  end

  always_comb begin
    next_state  = state;
    next_pos    = pos_x;
    next_health = health;
    if (hit_in && is_hittable(state)) begin
      if (moving_back) begin
        next_state = ST_BLOCK;
      end else if (health <= HW'(1)) begin
        next_health = '0;
        next_state  = ST_KO;
      end else begin
        next_health = health - HW'(1);
        next_state  = ST_DAMAGE;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (btn_attack)                next_state = ST_A1_STARTUP;
          else if (btn_left && !btn_right) next_state = ST_LEFT;
          else if (btn_right && !btn_left) next_state = ST_RIGHT;
        end
        ST_LEFT: begin
          if (btn_attack)     next_state = ST_A2_STARTUP;
          else if (!btn_left) next_state = btn_right ? ST_RIGHT : ST_IDLE;
          else                next_pos   = XW'(step_l);
        end
        ST_RIGHT: begin
          if (btn_attack)      next_state = ST_A2_STARTUP;
          else if (!btn_right) next_state = btn_left ? ST_LEFT : ST_IDLE;
          else                 next_pos   = XW'(step_r);
        end
        ST_A1_STARTUP:  if (phase_expire) next_state = ST_A1_ACTIVE;
        ST_A1_ACTIVE:   if (phase_expire) next_state = ST_A1_RECOVERY;
        ST_A1_RECOVERY: if (phase_expire) next_state = ST_IDLE;
        ST_A2_STARTUP:  if (phase_expire) next_state = ST_A2_ACTIVE;
        ST_A2_ACTIVE:   if (phase_expire) next_state = ST_A2_RECOVERY;
        ST_A2_RECOVERY: if (phase_expire) next_state = ST_IDLE;
        ST_DAMAGE:      if (phase_expire) next_state = ST_IDLE;
        ST_BLOCK:       if (phase_expire) next_state = ST_IDLE;
        default:        next_state = state;
      endcase
    end
  end

  // Every state change restarts the counter, so each phase begins at zero
  fighter_phase_timer #(.CW(CW)) u_timer (
    .clk    (clk_game),
    .reset  (reset),
    .tick   (frame_tick),
    .clear  (next_state != state),
    .last   (phase_last),
    .expire (phase_expire)
  );

  always_ff @(posedge clk_game) begin
    if (reset) begin
      state         <= ST_IDLE;
      pos_x         <= XW'(START_X);
      health        <= HW'(HEALTH_MAX);
      attack_active <= 1'b0;
      attack_heavy  <= 1'b0;
      ko            <= 1'b0;
    end else if (frame_tick) begin
      state         <= next_state;
      pos_x         <= next_pos;
      health        <= next_health;
      attack_active <= (next_state == ST_A1_ACTIVE) || (next_state == ST_A2_ACTIVE);
      attack_heavy  <= (next_state >= ST_A2_STARTUP) && (next_state <= ST_A2_RECOVERY);
      ko            <= (next_state == ST_KO);
    end
  end

endmodule

// File: tb/tb_fighter_fsm.sv
// tb/tb_fighter_fsm.sv - self-checking bench for fighter_fsm
module tb_fighter_fsm;

  localparam int START = 100;
  localparam int CHW = 128, SF = 3, SB = 2, GAP = 4;
  localparam int A1S = 5, A1A = 2, A1R = 16, A2S = 4, A2A = 3, A2R = 15;
  localparam int HITSTUN = 15, BLOCKSTUN = 10, HMAX = 3;

  logic       clk_game, reset, frame_tick, btn_left, btn_right, btn_attack, hit_in;
  logic [9:0] opp_x, pos_x;
  logic [3:0] state;
  logic [1:0] health;
  logic       attack_active, attack_heavy, ko;

  fighter_fsm #(.FACING_RIGHT(1), .XW(10), .START_X(START)) dut (
    .clk_game(clk_game), .reset(reset), .frame_tick(frame_tick),
    .btn_left(btn_left), .btn_right(btn_right), .btn_attack(btn_attack),
    .opp_x(opp_x), .hit_in(hit_in), .state(state), .pos_x(pos_x),
    .attack_active(attack_active), .attack_heavy(attack_heavy),
    .health(health), .ko(ko)
  );

  initial clk_game = 1'b0;
  always #5 clk_game = ~clk_game;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 walking, 2 attacking, 3 hitstun, 4 blockstun, 5 knocked out
  int m_mode, m_dir, m_t, m_rem, m_pos, m_hp;
  bit m_heavy;

  function automatic int m_state();
    int s, a;
    case (m_mode)
      0: return 0;
      1: return m_dir ? 2 : 1;
      2: begin
        s = m_heavy ? A2S : A1S;
        a = m_heavy ? A2A : A1A;
        return (m_heavy ? 6 : 3) + ((m_t < s) ? 0 : (m_t < s + a) ? 1 : 2);
      end
      3: return 9;
      4: return 10;
      default: return 11;
    endcase
  endfunction

  task automatic model_step(input bit tk, l, r, a, h, rs, input int opp);
    bit held, other;
    if (rs) begin
      m_mode = 0; m_pos = START; m_hp = HMAX;
      return;
    end
    if (!tk || m_mode == 5) return;
    if (h && m_mode <= 2) begin
      if (m_mode == 1 && m_dir == 0) begin
        m_mode = 4; m_rem = BLOCKSTUN;
      end else begin
        m_hp = m_hp - 1;
        if (m_hp == 0) m_mode = 5;
        else begin m_mode = 3; m_rem = HITSTUN; end
      end
      return;
    end
    case (m_mode)
      0: begin
        if (a) begin m_mode = 2; m_heavy = 0; m_t = 0; end
        else if (l != r) begin m_mode = 1; m_dir = r ? 1 : 0; end
      end
      1: begin
        held  = m_dir ? r : l;
        other = m_dir ? l : r;
        if (a) begin m_mode = 2; m_heavy = 1; m_t = 0; end
        else if (!held) begin
          if (other) m_dir = 1 - m_dir;
          else m_mode = 0;
        end else if (m_dir) begin
          if (m_pos + CHW + SF + GAP <= opp) m_pos = m_pos + SF;
        end else begin
          m_pos = (m_pos > SB) ? m_pos - SB : 0;
        end
      end
      2: begin
        m_t++;
        if (m_t == (m_heavy ? A2S + A2A + A2R : A1S + A1A + A1R)) m_mode = 0;
      end
      default: begin
        m_rem--;
        if (m_rem == 0) m_mode = 0;
      end
    endcase
  endtask

  task automatic step(input bit tk, l, r, a, h, rs);
    frame_tick = tk; btn_left = l; btn_right = r; btn_attack = a; hit_in = h; reset = rs;
    model_step(tk, l, r, a, h, rs, int'(opp_x));
    @(posedge clk_game);
    #1;
  endtask

  task automatic check_all(input string tag, input int st, input int pos, input int hp);
    chk({tag, "_state"}, int'(state), st);
    chk({tag, "_pos"}, int'(pos_x), pos);
    chk({tag, "_health"}, int'(health), hp);
    chk({tag, "_active"}, int'(attack_active), (st == 4 || st == 7) ? 1 : 0);
    chk({tag, "_heavy"}, int'(attack_heavy), (st >= 6 && st <= 8) ? 1 : 0);
    chk({tag, "_ko"}, int'(ko), (st == 11) ? 1 : 0);
  endtask

  typedef struct {
    bit tk, l, r, a, h, rs;
    int st, pos, hp;
  } vec_t;

  function automatic vec_t v(input bit tk, l, r, a, h, rs, input int st, pos, hp);
    vec_t x;
    x.tk = tk; x.l = l; x.r = r; x.a = a; x.h = h; x.rs = rs;
    x.st = st; x.pos = pos; x.hp = hp;
    return x;
  endfunction

  vec_t tbl[20];
  int n_st, n_ac, n_rc, n_act, n_hv, ticks;

  task automatic tally();
    case (int'(state))
      3, 6: n_st++;
      4, 7: n_ac++;
      5, 8: n_rc++;
      default: ;
    endcase
    if (attack_active) n_act++;
    if (attack_heavy) n_hv++;
  endtask

  initial begin
    reset = 1'b1; frame_tick = 0; btn_left = 0; btn_right = 0; btn_attack = 0; hit_in = 0;
    opp_x = 10'd400;

    //            tk l  r  a  h  rs  state pos  hp
    tbl[0]  = v(0, 0, 0, 0, 0, 1,  0, 100, 3);
    tbl[1]  = v(1, 0, 1, 0, 0, 0,  2, 100, 3);
    tbl[2]  = v(1, 0, 1, 0, 0, 0,  2, 103, 3);
    tbl[3]  = v(0, 0, 1, 0, 0, 0,  2, 103, 3);
    tbl[4]  = v(1, 0, 1, 1, 0, 0,  6, 103, 3);
    tbl[5]  = v(1, 0, 0, 0, 1, 0,  9, 103, 2);
    tbl[6]  = v(1, 0, 0, 0, 1, 0,  9, 103, 2);
    tbl[7]  = v(0, 0, 0, 0, 0, 1,  0, 100, 3);
    tbl[8]  = v(1, 1, 0, 0, 0, 0,  1, 100, 3);
    tbl[9]  = v(1, 1, 0, 0, 0, 0,  1,  98, 3);
    tbl[10] = v(1, 1, 0, 0, 1, 0, 10,  98, 3);
    tbl[11] = v(1, 0, 0, 0, 1, 0, 10,  98, 3);
    tbl[12] = v(1, 1, 1, 1, 0, 0, 10,  98, 3);
    tbl[13] = v(0, 0, 0, 0, 0, 1,  0, 100, 3);
    tbl[14] = v(1, 0, 0, 1, 0, 0,  3, 100, 3);
    tbl[15] = v(0, 0, 0, 0, 1, 0,  3, 100, 3);
    tbl[16] = v(1, 0, 0, 0, 1, 0,  9, 100, 2);
    tbl[17] = v(0, 0, 0, 0, 0, 1,  0, 100, 3);
    tbl[18] = v(1, 1, 1, 0, 0, 0,  0, 100, 3);
    tbl[19] = v(1, 0, 0, 0, 0, 0,  0, 100, 3);
    for (int i = 0; i < 20; i++) begin
      step(tbl[i].tk, tbl[i].l, tbl[i].r, tbl[i].a, tbl[i].h, tbl[i].rs);
      check_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].pos, tbl[i].hp);
    end

    // Light attack timing with gaps in frame_tick
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 0, 1, 0, 0);
    n_st = 0; n_ac = 0; n_rc = 0; n_act = 0; n_hv = 0; ticks = 0;
    tally();
    for (int c = 0; c < 300 && state != 4'd0; c++) begin
      bit tk;
      tk = ($urandom % 3) != 0;
      step(tk, 0, 0, 0, 0, 0);
      if (tk) begin
        ticks++;
        if (state != 4'd0) tally();
      end else begin
        chk("a1_hold", int'(state), m_state());
      end
    end
    chk("a1_startup_ticks", n_st, 5);
    chk("a1_active_ticks", n_ac, 2);
    chk("a1_active_out", n_act, 2);
    chk("a1_recovery_ticks", n_rc, 16);
    chk("a1_total_ticks", ticks, 23);
    chk("a1_end_idle", int'(state), 0);

    // Heavy attack out of a walk
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    n_st = 0; n_ac = 0; n_rc = 0; n_act = 0; n_hv = 0; ticks = 0;
    tally();
    for (int c = 0; c < 100 && state != 4'd0; c++) begin
      step(1, 0, 1, 1, 0, 0);
      ticks++;
      if (state != 4'd0) tally();
    end
    chk("a2_startup_ticks", n_st, 4);
    chk("a2_active_ticks", n_ac, 3);
    chk("a2_recovery_ticks", n_rc, 15);
    chk("a2_heavy_ticks", n_hv, 22);
    chk("a2_total_ticks", ticks, 22);

    // Walk forward into the opponent: last legal step lands at 268 (268+128+4 = 400)
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 60; i++) step(1, 0, 1, 0, 0, 0);
    chk("walk_stop_pos", int'(pos_x), 268);
    step(1, 0, 1, 0, 0, 0);
    chk("walk_hold_pos", int'(pos_x), 268);
    chk("walk_state", int'(state), 2);

    // Back-walk clamp at the left edge
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("clamp_switch_pos", int'(pos_x), 103);
    for (int i = 0; i < 51; i++) step(1, 1, 0, 0, 0, 0);
    chk("clamp_pos1", int'(pos_x), 1);
    step(1, 1, 0, 0, 0, 0);
    chk("clamp_pos0", int'(pos_x), 0);
    step(1, 1, 0, 0, 0, 0);
    chk("clamp_stay0", int'(pos_x), 0);

    // Three hits to KO, then KO is sticky
    step(0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 3; k++) begin
      step(1, 0, 0, 0, 1, 0);
      chk($sformatf("ko_hit%0d_health", k), int'(health), 3 - k);
      if (k < 3) begin
        chk($sformatf("ko_hit%0d_state", k), int'(state), 9);
        for (int i = 0; i < HITSTUN; i++) step(1, 0, 0, 0, 0, 0);
        chk($sformatf("ko_recover%0d", k), int'(state), 0);
      end
    end
    check_all("ko", 11, 100, 0);
    for (int i = 0; i < 20; i++)
      step(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 0);
    check_all("ko_sticky", 11, 100, 0);
    step(0, 0, 0, 0, 0, 1);
    check_all("ko_reset", 0, 100, 3);

    // Reset in the middle of an active window
    step(1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0);
    chk("midreset_pre_state", int'(state), 4);
    step(0, 0, 0, 0, 0, 1);
    check_all("midreset", 0, 100, 3);

    // Randomized run against the model
    step(0, 0, 0, 0, 0, 1);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom % 50 == 0) opp_x = 10'($urandom_range(150, 700));
      step(($urandom % 4) != 0, 1'($urandom), 1'($urandom), ($urandom % 4) == 0,
           ($urandom % 12) == 0, ($urandom % 300) == 0);
      check_all("rnd", m_state(), m_pos, m_hp);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
